// File: rtl/mux_scan_pkg.sv
// Shared definitions for the MUX_4x1 channel scanner.
// - scan_state_e : scanner FSM state encoding
// - NUM_CH       : number of mux channels (fixed at 4 to match MUX_4x1)
// - next_enabled : lowest enabled channel at or above a starting index
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } next_ch_t;

  // Priority search for the lowest set mask bit with index >= from.
  // from is 3 bits wide so that "above channel 3" (4) finds nothing,
  // which keeps a scan from wrapping back to channel 0.
  function automatic next_ch_t next_enabled(input logic [3:0] mask, input logic [2:0] from);
    next_ch_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        r.found = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_channel_scanner_timer.sv
// scan_settle_timer: settle-time counter for the channel scanner.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : clear the count (takes priority over en)
//   en         : advance the count by one
//   tc         : high while the count shows the last settle cycle,
//                i.e. SETTLE_CYCLES cycles have elapsed at the next edge
module scan_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (en) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner: drives MUX_4x1 select lines through the enabled
// channels in ascending order, samples mux_y after a settle time into
// result[ch], and offers the snapshot on a valid/ready handshake.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start, ch_mask   : scan request (IDLE only) and channel enable mask
//   abort            : cancel an in-progress scan (SETTLE/CAPTURE only)
//   mux_y            : mux output
//   sel1, sel0       : mux select
//   busy             : scan in progress
//   out_valid/ready  : result handshake
//   result           : sampled channel values, masked channels read 0
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] ch_mask,
  input  logic       abort,
  input  logic       mux_y,
  output logic       sel1,
  output logic       sel0,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] result
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("mux_channel_scanner: SETTLE_CYCLES must be in 1..15");
  end

  scan_state_e state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  result_q, result_d;
  logic        cnt_clr, cnt_en, cnt_tc;
  next_ch_t    nxt;

  scan_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mask_d   = mask_q;
    result_d = result_q;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    nxt      = '0;
    unique case (state_q)
      StIdle: begin
        // abort is ignored here; start alone decides.
        if (start) begin
          mask_d   = ch_mask;
          result_d = 4'h0;
          nxt      = next_enabled(ch_mask, 3'd0);
          if (nxt.found) begin
            sel_d   = nxt.idx;
            state_d = StSettle;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        if (abort) begin
          result_d = 4'h0;
          state_d  = StIdle;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
            state_d = StCapture;
          end
        end
      end
      StCapture: begin
        if (abort) begin
          result_d = 4'h0;
          state_d  = StIdle;
        end else begin
          result_d[sel_q] = mux_y;
          nxt = next_enabled(mask_q, {1'b0, sel_q} + 3'd1);
          if (nxt.found) begin
            sel_d   = nxt.idx;
            state_d = StSettle;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= 2'd0;
      mask_q   <= 4'h0;
      result_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      result_q <= result_d;
    end
  end

  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];
  assign busy      = (state_q == StSettle) || (state_q == StCapture);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
module tb_mux_channel_scanner;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] ch_mask;
  logic       abort;
  logic       mux_y;
  logic       sel1, sel0;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic [3:0] mux_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural MUX_4x1
  assign mux_y = mux_data[{sel1, sel0}];

  mux_channel_scanner #(
    .SETTLE_CYCLES(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ch_mask  (ch_mask),
    .abort    (abort),
    .mux_y    (mux_y),
    .sel1     (sel1),
    .sel0     (sel0),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  typedef struct {
    logic [3:0] data;
    logic [3:0] mask;
    int         hold;
    logic [3:0] exp_res;
    int         exp_lat;
  } vec_t;

  // Start a scan, check the select sequence cycle by cycle against the
  // list of enabled channels, then latency, result and handshake.
  task automatic run_scan(input logic [3:0] data, input logic [3:0] mask,
                          input logic [3:0] exp_res, input int exp_lat,
                          input int hold, input bit noise);
    int t;
    int slot;
    logic [1:0] chans[$];
    chans = {};
    for (int i = 0; i < 4; i++) if (mask[i]) chans.push_back(2'(i));
    @(negedge clk);
    mux_data  = data;
    ch_mask   = mask;
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!out_valid && t < 400) begin
      slot = t / (S + 1);
      if (slot < chans.size()) chk("scan_sel", 32'({sel1, sel0}), 32'(chans[slot]));
      chk("scan_busy", 32'(busy), 32'd1);
      if (noise) begin
        ch_mask = 4'($urandom_range(0, 15));
        start   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      t++;
    end
    start   = 1'b0;
    ch_mask = mask;
    chk("latency", 32'(t), 32'(exp_lat));
    chk("result", 32'(result), 32'(exp_res));
    chk("done_busy", 32'(busy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(exp_res));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("xfer_valid", 32'(out_valid), 32'd0);
    chk("xfer_result_kept", 32'(result), 32'(exp_res));
  endtask

  task automatic wait_valid(input int bound);
    int t;
    t = 0;
    while (!out_valid && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("wait_valid", 32'(out_valid), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [3:0] d, m;
    rst_n     = 1'b0;
    start     = 1'b0;
    ch_mask   = 4'h0;
    abort     = 1'b0;
    out_ready = 1'b0;
    mux_data  = 4'h0;

    vecs[0] = '{4'h5, 4'hF, 0, 4'b0101, 12};
    vecs[1] = '{4'hA, 4'b1010, 5, 4'b1010, 6};
    vecs[2] = '{4'hF, 4'h0, 0, 4'h0, 0};
    vecs[3] = '{4'hF, 4'h1, 1, 4'h1, 3};
    vecs[4] = '{4'h6, 4'h8, 0, 4'h0, 3};
    vecs[5] = '{4'h9, 4'h9, 2, 4'h9, 6};

    repeat (2) @(negedge clk);
    chk("rst_sel", 32'({sel1, sel0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;

    // Empty mask right after reset: select must stay 00.
    @(negedge clk);
    ch_mask = 4'h0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_valid", 32'(out_valid), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_sel", 32'({sel1, sel0}), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("empty_xfer", 32'(out_valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].data, vecs[i].mask, vecs[i].exp_res, vecs[i].exp_lat, vecs[i].hold, 1'b0);
    end

    // Abort during SETTLE of channel 2 on a full scan.
    @(negedge clk);
    mux_data = 4'h5;
    ch_mask  = 4'hF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_sel", 32'({sel1, sel0}), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 15; i++) begin
      if (out_valid) chk("abort_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("abort_idle_busy", 32'(busy), 32'd0);
    run_scan(4'h5, 4'hF, 4'b0101, 12, 0, 1'b0);

    // Start together with abort in IDLE: start wins.
    @(negedge clk);
    mux_data = 4'h1;
    ch_mask  = 4'h1;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_wins_busy", 32'(busy), 32'd1);
    wait_valid(20);
    chk("start_wins_result", 32'(result), 32'h1);

    // start/abort while waiting in DONE are ignored.
    start    = 1'b1;
    abort    = 1'b1;
    ch_mask  = 4'hF;
    mux_data = 4'h0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("done_ign_valid", 32'(out_valid), 32'd1);
    chk("done_ign_busy", 32'(busy), 32'd0);
    chk("done_ign_result", 32'(result), 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_ign_xfer", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("done_ign_no_rescan", 32'(busy), 32'd0);

    // Reset during CAPTURE of channel 1 (bit 0 already captured).
    mux_data = 4'h5;
    ch_mask  = 4'hF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_result", 32'(result), 32'h1);
    chk("pre_rst_sel", 32'({sel1, sel0}), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_sel", 32'({sel1, sel0}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);

    // Randomized scans against the reference model: result is the mux data
    // under the mask, latency is enabled-channel count times (S+1).
    for (int i = 0; i < 25; i++) begin
      d = 4'($urandom_range(0, 15));
      m = 4'($urandom_range(0, 15));
      run_scan(d, m, d & m, $countones(m) * (S + 1), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
